// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use hazard, forwarding and memory-freeze controller for a 5-stage pipeline
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid                 valid instruction in ID
//   id_rs1, id_rs2           ID source register addresses
//   id_use_rs1, id_use_rs2   ID instruction actually reads rs1 / rs2
//   id_rd, id_wen, id_load   ID destination, write enable, load flag
//   mem_busy                 data memory not ready (freeze request)
//   pc_we, ifid_we           PC and IF/ID write enables (combinational)
//   idex_bubble              load a no-write bubble into ID/EXE (combinational)
//   fwd_a, fwd_b             registered EXE operand selects: 00 regfile, 01 EXE/MEM, 10 MEM/WB
//   ctrl_state               registered action of last cycle: 00 RUN, 01 LDSTALL, 10 FREEZE
//   stall_cycles             saturating count of non-RUN cycles

module pipe_hazard_ctrl #(
  parameter int AW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_wen,
  input  logic            id_load,
  input  logic            mem_busy,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            idex_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [1:0]      ctrl_state,
  output logic [CNTW-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ACT_RUN     = 2'b00,
    ACT_LDSTALL = 2'b01,
    ACT_FREEZE  = 2'b10
  } act_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // Shadow pipeline: destination info of the instructions now in EXE, MEM and WB.
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic          ex_wen, mem_wen, wb_wen;
  logic          ex_load, mem_load;

  act_e          state_q;
  logic [1:0]    fwd_a_q, fwd_b_q;
  logic [CNTW-1:0] stall_q;

  // Source/slot matches. Register 0 is hardwired zero, so it never matches.
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem, rs1_wb, rs2_wb;
  logic load_use;
  act_e action;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  assign rs1_ex  = id_valid && id_use_rs1 && ex_wen  && (ex_rd  != '0) && (id_rs1 == ex_rd);
  assign rs2_ex  = id_valid && id_use_rs2 && ex_wen  && (ex_rd  != '0) && (id_rs2 == ex_rd);
  assign rs1_mem = id_valid && id_use_rs1 && mem_wen && (mem_rd != '0) && (id_rs1 == mem_rd);
  assign rs2_mem = id_valid && id_use_rs2 && mem_wen && (mem_rd != '0) && (id_rs2 == mem_rd);
  assign rs1_wb  = id_valid && id_use_rs1 && wb_wen  && (wb_rd  != '0) && (id_rs1 == wb_rd);
  assign rs2_wb  = id_valid && id_use_rs2 && wb_wen  && (wb_rd  != '0) && (id_rs2 == wb_rd);

  // A load in EXE has no data until the end of MEM, so a dependent in ID must wait one cycle.
  assign load_use = ex_load && ex_wen && (rs1_ex || rs2_ex);

  always_comb begin
    action = ACT_RUN;
    if (mem_busy) begin
      action = ACT_FREEZE;
    end else if (load_use) begin
      action = ACT_LDSTALL;
    end
  end

  assign pc_we       = (action == ACT_RUN);
  assign ifid_we     = (action == ACT_RUN);
  assign idex_bubble = (action == ACT_LDSTALL);

  // Youngest writer wins. A WB-only match stays on the register file: it
  // writes in the first half-cycle, so the read already sees the new value.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem,
                                         input logic hit_wb, input logic ex_is_load);
    logic [1:0] sel;
    sel = FWD_RF;
    if (hit_ex && !ex_is_load) begin
      sel = FWD_EXE;
    end else if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  assign fwd_a_nxt = fwd_sel(rs1_ex, rs1_mem, rs1_wb, ex_load);
  assign fwd_b_nxt = fwd_sel(rs2_ex, rs2_mem, rs2_wb, ex_load);

  // mem_load is carried along with its slot but no decision depends on it.
  logic unused_shadow;
  assign unused_shadow = mem_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rd    <= '0;
      ex_wen   <= 1'b0;
      ex_load  <= 1'b0;
      mem_rd   <= '0;
      mem_wen  <= 1'b0;
      mem_load <= 1'b0;
      wb_rd    <= '0;
      wb_wen   <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      state_q  <= ACT_RUN;
      stall_q  <= '0;
    end else begin
      state_q <= action;
      if (action != ACT_RUN && stall_q != CNT_MAX) begin
        stall_q <= stall_q + CNT_ONE;
      end
      unique case (action)
        ACT_FREEZE: begin
          // Whole pipeline frozen: shadow and forward selects hold.
        end
        ACT_LDSTALL: begin
          wb_rd    <= mem_rd;
          wb_wen   <= mem_wen;
          mem_rd   <= ex_rd;
          mem_wen  <= ex_wen;
          mem_load <= ex_load;
          ex_rd    <= '0;
          ex_wen   <= 1'b0;
          ex_load  <= 1'b0;
          fwd_a_q  <= FWD_RF;
          fwd_b_q  <= FWD_RF;
        end
        default: begin
          wb_rd    <= mem_rd;
          wb_wen   <= mem_wen;
          mem_rd   <= ex_rd;
          mem_wen  <= ex_wen;
          mem_load <= ex_load;
          ex_rd    <= id_rd;
          ex_wen   <= id_wen && id_valid;
          ex_load  <= id_load && id_valid;
          fwd_a_q  <= fwd_a_nxt;
          fwd_b_q  <= fwd_b_nxt;
        end
      endcase
    end
  end

  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign ctrl_state   = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_wen, id_load;
  logic       mem_busy;

  logic        pc_we, ifid_we, idex_bubble;
  logic [1:0]  fwd_a, fwd_b, ctrl_state;
  logic [15:0] stall_cycles;

  logic        pc_we4, ifid_we4, idex_bubble4;
  logic [1:0]  fwd_a4, fwd_b4, ctrl_state4;
  logic [3:0]  stall_cycles4;

  int n_cmp;
  int n_fail;

  pipe_hazard_ctrl #(.AW(5), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_load(id_load), .mem_busy(mem_busy), .pc_we(pc_we), .ifid_we(ifid_we),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.AW(5), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_load(id_load), .mem_busy(mem_busy), .pc_we(pc_we4), .ifid_we(ifid_we4),
    .idex_bubble(idex_bubble4), .fwd_a(fwd_a4), .fwd_b(fwd_b4), .ctrl_state(ctrl_state4),
    .stall_cycles(stall_cycles4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight writers, index 0 = youngest (EXE), 1 = MEM, 2 = WB.
  typedef struct {
    logic [4:0] rd;
    bit         wen;
    bit         load;
  } ent_t;

  ent_t q[$];
  int   m_fwd_a, m_fwd_b, m_state, m_stall, m_stall4;

  function automatic bit writes(ent_t e, logic [4:0] r);
    return e.wen && (e.rd == r) && (r != 5'd0);
  endfunction

  // 0 RUN, 1 LDSTALL, 2 FREEZE
  function automatic int m_action();
    bit hit;
    if (mem_busy) return 2;
    hit = id_valid && q[0].load &&
          ((id_use_rs1 && writes(q[0], id_rs1)) || (id_use_rs2 && writes(q[0], id_rs2)));
    return hit ? 1 : 0;
  endfunction

  function automatic int m_fsel(bit use_it, logic [4:0] rs);
    if (!(id_valid && use_it)) return 0;
    if (writes(q[0], rs) && !q[0].load) return 1;
    if (writes(q[1], rs)) return 2;
    return 0;
  endfunction

  function automatic void m_reset();
    ent_t z;
    z.rd = 5'd0; z.wen = 1'b0; z.load = 1'b0;
    q = {};
    for (int i = 0; i < 3; i++) q.push_back(z);
    m_fwd_a = 0; m_fwd_b = 0; m_state = 0; m_stall = 0; m_stall4 = 0;
  endfunction

  task automatic set_instr(input bit v, input int rs1, input int rs2, input bit u1,
                           input bit u2, input int rd, input bit wen, input bit ld);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = 5'(rd); id_wen = wen; id_load = ld;
  endtask

  task automatic set_idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock and the model with it; returns #1 after the edge.
  task automatic tick();
    int   a;
    ent_t e;
    a = m_action();
    @(posedge clk);
    m_state = a;
    if (a != 0) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (a == 1) begin
      e.rd = 5'd0; e.wen = 1'b0; e.load = 1'b0;
      q.push_front(e); void'(q.pop_back());
      m_fwd_a = 0; m_fwd_b = 0;
    end else if (a == 0) begin
      m_fwd_a = m_fsel(id_use_rs1, id_rs1);
      m_fwd_b = m_fsel(id_use_rs2, id_rs2);
      e.rd = id_rd; e.wen = id_wen && id_valid; e.load = id_load && id_valid;
      q.push_front(e); void'(q.pop_back());
    end
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    mem_busy = 1'b0;
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    mem_busy = 1'b0;
    rst = 1'b0;
    m_reset();
    #2;
    n_cmp++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL reset_pc_we: got %0d want 1", pc_we); end
    n_cmp++; if (ifid_we !== 1'b1) begin n_fail++; $display("FAIL reset_ifid_we: got %0d want 1", ifid_we); end
    n_cmp++; if (idex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble: got %0d want 0", idex_bubble); end
    n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_a, fwd_b); end
    n_cmp++; if (ctrl_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d want 0", ctrl_state); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (ctrl_state !== 2'b00) begin n_fail++; $display("FAIL first_run_state: got %0d want 0", ctrl_state); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_instr(1, 1, 2, 1, 1, 3, 1, 0);          // add x3,x1,x2
    tick();
    set_instr(1, 3, 4, 1, 1, 5, 1, 0);          // sub x5,x3,x4
    @(negedge clk);
    n_cmp++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin n_fail++; $display("FAIL b2b_nostall: got pc_we=%0d bubble=%0d want 1/0", pc_we, idex_bubble); end
    tick();
    set_instr(1, 3, 0, 1, 1, 9, 1, 0);          // and x9,x3,x0
    @(negedge clk);
    n_cmp++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL b2b_fwd_exe: got %0d/%0d want 1/0", fwd_a, fwd_b); end
    tick();
    set_idle();
    @(negedge clk);
    n_cmp++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL b2b_fwd_mem: got %0d/%0d want 2/0", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(1, 1, 0, 1, 0, 7, 1, 1);          // ld x7
    tick();
    set_instr(1, 7, 7, 1, 1, 8, 1, 0);          // add x8,x7,x7
    @(negedge clk);
    n_cmp++; if (pc_we !== 1'b0 || ifid_we !== 1'b0 || idex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got pc=%0d ifid=%0d bub=%0d want 0/0/1", pc_we, ifid_we, idex_bubble); end
    tick();
    @(negedge clk);
    n_cmp++; if (ctrl_state !== 2'b01) begin n_fail++; $display("FAIL lu_state: got %0d want 1", ctrl_state); end
    n_cmp++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL lu_resume: got %0d want 1", pc_we); end
    tick();
    set_idle();
    @(negedge clk);
    n_cmp++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin n_fail++; $display("FAIL lu_fwd: got %0d/%0d want 2/2", fwd_a, fwd_b); end
    n_cmp++; if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_count: got %0d want 1", stall_cycles); end
    tick();
  endtask

  task automatic test_x0_priority();
    do_reset();
    set_instr(1, 1, 0, 1, 0, 0, 1, 1);          // ld x0
    tick();
    set_instr(1, 0, 0, 1, 1, 4, 1, 0);          // add x4,x0,x0
    @(negedge clk);
    n_cmp++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin n_fail++; $display("FAIL x0_nostall: got pc=%0d bub=%0d want 1/0", pc_we, idex_bubble); end
    tick();
    set_instr(1, 1, 2, 1, 1, 6, 1, 0);          // add x6
    @(negedge clk);
    n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL x0_nofwd: got %0d/%0d want 0/0", fwd_a, fwd_b); end
    tick();
    set_instr(1, 1, 2, 0, 0, 6, 1, 0);          // second writer of x6
    tick();
    set_instr(1, 6, 6, 1, 1, 10, 1, 0);         // reads x6 twice
    tick();
    set_idle();
    @(negedge clk);
    n_cmp++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin n_fail++; $display("FAIL youngest_wins: got %0d/%0d want 1/1", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_freeze_ldstall();
    do_reset();
    set_instr(1, 1, 0, 1, 0, 7, 1, 1);          // ld x7
    tick();
    set_instr(1, 7, 2, 1, 1, 8, 1, 0);          // add x8,x7,x2
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (pc_we !== 1'b0 || idex_bubble !== 1'b0) begin n_fail++; $display("FAIL freeze_%0d: got pc=%0d bub=%0d want 0/0", i, pc_we, idex_bubble); end
      tick();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    n_cmp++; if (ctrl_state !== 2'b10 || idex_bubble !== 1'b1) begin n_fail++; $display("FAIL freeze_release: got state=%0d bub=%0d want 2/1", ctrl_state, idex_bubble); end
    tick();
    @(negedge clk);
    n_cmp++; if (ctrl_state !== 2'b01 || pc_we !== 1'b1) begin n_fail++; $display("FAIL freeze_ldstall: got state=%0d pc=%0d want 1/1", ctrl_state, pc_we); end
    tick();
    set_idle();
    @(negedge clk);
    n_cmp++; if (stall_cycles !== 16'd4 || fwd_a !== 2'b10) begin n_fail++; $display("FAIL freeze_count: got stall=%0d fwd_a=%0d want 4/2", stall_cycles, fwd_a); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    set_instr(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    set_instr(1, 3, 4, 1, 1, 5, 1, 0);
    tick();
    set_idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (stall_cycles !== 16'd5 || fwd_a !== 2'b01) begin n_fail++; $display("FAIL pre_reset: got stall=%0d fwd_a=%0d want 5/1", stall_cycles, fwd_a); end
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    n_cmp++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL async_stall: got %0d want 0", stall_cycles); end
    n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || ctrl_state !== 2'b00) begin n_fail++; $display("FAIL async_regs: got fwd=%0d/%0d state=%0d want 0/0/0", fwd_a, fwd_b, ctrl_state); end
    mem_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    mem_busy = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall_cycles4 !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4: got %0d want 15", stall_cycles4); end
    n_cmp++; if (stall_cycles !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16: got %0d want 20", stall_cycles); end
    tick();
  endtask

  task automatic test_random();
    int a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_instr($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      a = m_action();
      n_cmp++; if (pc_we !== (a == 0) || ifid_we !== (a == 0)) begin n_fail++; $display("FAIL rnd_we[%0d]: got pc=%0d ifid=%0d want %0d", n, pc_we, ifid_we, a == 0); end
      n_cmp++; if (idex_bubble !== (a == 1)) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %0d want %0d", n, idex_bubble, a == 1); end
      n_cmp++; if (fwd_a !== 2'(m_fwd_a) || fwd_b !== 2'(m_fwd_b)) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got %0d/%0d want %0d/%0d", n, fwd_a, fwd_b, m_fwd_a, m_fwd_b); end
      n_cmp++; if (ctrl_state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", n, ctrl_state, m_state); end
      n_cmp++; if (stall_cycles !== 16'(m_stall) || stall_cycles4 !== 4'(m_stall4)) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0d/%0d want %0d/%0d", n, stall_cycles, stall_cycles4, m_stall, m_stall4); end
      n_cmp++; if (pc_we4 !== pc_we || ifid_we4 !== ifid_we || idex_bubble4 !== idex_bubble ||
                   fwd_a4 !== 2'(m_fwd_a) || fwd_b4 !== 2'(m_fwd_b) || ctrl_state4 !== 2'(m_state)) begin
        n_fail++; $display("FAIL rnd_cnt4_inst[%0d]: got pc=%0d fwd=%0d/%0d state=%0d want fwd=%0d/%0d state=%0d", n, pc_we4, fwd_a4, fwd_b4, ctrl_state4, m_fwd_a, m_fwd_b, m_state);
      end
      tick();
    end
    mem_busy = 1'b0;
    set_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    mem_busy = 1'b0;
    set_idle();
    m_reset();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_priority();
    test_freeze_ldstall();
    test_reset_mid_run();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
